feature_map_mem: RTL and testbench

Banked feature-map storage for the 8×8×32 image pipeline. It answers the core controller's memory interface. The core issues single-byte writes addressed by (x, y, channel) and wide reads addressed by (x, y, bank). For each read the block returns one byte from each of the 16 SRAMs, so 16 channels arrive per access. After reset it clears its own contents and then signals ready.

---
 rtl/feature_map_pkg.sv | 28 ++
 rtl/sram_128x8.sv | 21 ++
 rtl/feature_map_mem.sv | 125 ++++++++++++
 tb/tb_feature_map_mem.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/feature_map_pkg.sv
// Shared constants, state encoding and address helpers for the banked
// 8x8x32 feature-map store.
package feature_map_pkg;

  localparam int unsigned IMG_W      = 8;
  localparam int unsigned IMG_H      = 8;
  localparam int unsigned NUM_SRAM   = 16;
  localparam int unsigned NUM_BANK   = 2;
  localparam int unsigned SRAM_DEPTH = 128;
  localparam int unsigned ADDR_W     = 7;

  typedef enum logic {INIT, RUN} state_t;

  // Word address {bank, y-1, x-1}; coordinates are 1-based.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [3:0] x,
                                                  input logic [3:0] y,
                                                  input logic       bank);
    return {bank, 3'(y - 4'd1), 3'(x - 4'd1)};
  endfunction

  function automatic logic in_range(input logic [3:0]  x,
                                    input logic [3:0]  y,
                                    input int unsigned w,
                                    input int unsigned h);
    return (x != 4'd0) && (32'(x) <= w) && (y != 4'd0) && (32'(y) <= h);
  endfunction

endpackage

// File: rtl/sram_128x8.sv
// 128x8 simple dual-port SRAM: one synchronous write port, one registered
// read port, read-before-write on an address collision.
module sram_128x8
  import feature_map_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [SRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/feature_map_mem.sv
// Banked feature-map storage: byte writes by (x, y, channel), 16-channel
// wide reads by (x, y, bank), zero padding outside the image, self-clear.
module feature_map_mem #(
  parameter int unsigned IMG_W    = feature_map_pkg::IMG_W,
  parameter int unsigned IMG_H    = feature_map_pkg::IMG_H,
  parameter int unsigned NUM_SRAM = feature_map_pkg::NUM_SRAM,
  parameter int unsigned NUM_BANK = feature_map_pkg::NUM_BANK
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_ready,
  input  logic [3:0] i_write_x,
  input  logic [3:0] i_write_y,
  input  logic [4:0] i_write_channel,
  input  logic [7:0] i_write_data,
  input  logic       i_write_enable,
  input  logic [3:0] i_read_x,
  input  logic [3:0] i_read_y,
  input  logic       i_read_bank,
  output logic [7:0] o_sram0_data,
  output logic [7:0] o_sram1_data,
  output logic [7:0] o_sram2_data,
  output logic [7:0] o_sram3_data,
  output logic [7:0] o_sram4_data,
  output logic [7:0] o_sram5_data,
  output logic [7:0] o_sram6_data,
  output logic [7:0] o_sram7_data,
  output logic [7:0] o_sram8_data,
  output logic [7:0] o_sram9_data,
  output logic [7:0] o_sram10_data,
  output logic [7:0] o_sram11_data,
  output logic [7:0] o_sram12_data,
  output logic [7:0] o_sram13_data,
  output logic [7:0] o_sram14_data,
  output logic [7:0] o_sram15_data
);

  import feature_map_pkg::*;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                pad;
  logic                wr_sel;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [7:0]          wr_data;
  logic [NUM_SRAM-1:0] wr_en;
  logic [7:0]          rd_data  [NUM_SRAM];
  logic [7:0]          out_data [NUM_SRAM];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
      pad     <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
      // Padding flag is registered with the read address so it lines up with the data.
      pad <= (state != RUN) || !in_range(i_read_x, i_read_y, IMG_W, IMG_H);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (clr_cnt == '1) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    wr_sel  = i_write_enable
              && in_range(i_write_x, i_write_y, IMG_W, IMG_H)
              && (32'(i_write_channel) < NUM_SRAM * NUM_BANK);
    wr_addr = word_addr(i_write_x, i_write_y, i_write_channel[4]);
    wr_data = i_write_data;
    wr_en   = '0;
    if (state == INIT) begin
      wr_addr = clr_cnt;
      wr_data = '0;
      wr_en   = '1;
    end else begin
      for (int unsigned k = 0; k < NUM_SRAM; k++)
        wr_en[k] = wr_sel && (i_write_channel[3:0] == 4'(k));
    end
  end

  assign rd_addr = word_addr(i_read_x, i_read_y, i_read_bank);

  for (genvar k = 0; k < NUM_SRAM; k++) begin : g_sram
    sram_128x8 u_sram (
      .clk   (i_clk),
      .we    (wr_en[k]),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (rd_data[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_SRAM; k++)
      out_data[k] = pad ? '0 : rd_data[k];
  end

  assign o_ready       = (state == RUN);
  assign o_sram0_data  = out_data[0];
  assign o_sram1_data  = out_data[1];
  assign o_sram2_data  = out_data[2];
  assign o_sram3_data  = out_data[3];
  assign o_sram4_data  = out_data[4];
  assign o_sram5_data  = out_data[5];
  assign o_sram6_data  = out_data[6];
  assign o_sram7_data  = out_data[7];
  assign o_sram8_data  = out_data[8];
  assign o_sram9_data  = out_data[9];
  assign o_sram10_data = out_data[10];
  assign o_sram11_data = out_data[11];
  assign o_sram12_data = out_data[12];
  assign o_sram13_data = out_data[13];
  assign o_sram14_data = out_data[14];
  assign o_sram15_data = out_data[15];

endmodule

// File: tb/tb_feature_map_mem.sv
// Directed bench for feature_map_mem: init sweep, bank routing, padding,
// read-before-write collision, reset mid-operation and a full load/readback.
module tb_feature_map_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic [3:0] write_x, write_y, read_x, read_y;
  logic [4:0] write_channel;
  logic [7:0] write_data;
  logic       write_enable, read_bank;
  logic [7:0] q [16];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  feature_map_mem dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(ready),
    .i_write_x(write_x), .i_write_y(write_y), .i_write_channel(write_channel),
    .i_write_data(write_data), .i_write_enable(write_enable),
    .i_read_x(read_x), .i_read_y(read_y), .i_read_bank(read_bank),
    .o_sram0_data(q[0]),   .o_sram1_data(q[1]),   .o_sram2_data(q[2]),
    .o_sram3_data(q[3]),   .o_sram4_data(q[4]),   .o_sram5_data(q[5]),
    .o_sram6_data(q[6]),   .o_sram7_data(q[7]),   .o_sram8_data(q[8]),
    .o_sram9_data(q[9]),   .o_sram10_data(q[10]), .o_sram11_data(q[11]),
    .o_sram12_data(q[12]), .o_sram13_data(q[13]), .o_sram14_data(q[14]),
    .o_sram15_data(q[15])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expect value `val` on output `hot` and 0x00 on every other output.
  task automatic check_outs(input string tag, input int hot, input logic [7:0] val);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s q%0d", tag, k), 32'(q[k]), (k == hot) ? 32'(val) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic [4:0] ch,
                    input logic [7:0] d);
    write_x = x; write_y = y; write_channel = ch; write_data = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic set_rd(input logic [3:0] x, input logic [3:0] y, input logic b);
    read_x = x; read_y = y; read_bank = b;
  endtask

  function automatic logic [7:0] pattern(input int ch, input int x, input int y);
    return 8'((ch * 64 + (y - 1) * 8 + (x - 1)) % 256);
  endfunction

  // Release at a falling edge so the next rising edge is cycle 1; check ready per cycle.
  task automatic release_and_init(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      tick();
      check($sformatf("%s ready c%0d", tag, c), 32'(ready), (c >= 128) ? 32'd1 : 32'd0);
      if (c == 1 || c == 64 || c == 127 || c == 129) check_outs($sformatf("%s c%0d", tag, c), -1, 8'h00);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    write_x = '0; write_y = '0; write_channel = '0; write_data = '0; write_enable = 1'b0;
    read_x = '0; read_y = '0; read_bank = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset ready", 32'(ready), 32'd0);
    check_outs("reset", -1, 8'h00);
    tick(); tick();
    release_and_init("init");

    // Bank routing
    wr(4'd1, 4'd1, 5'd5, 8'hA5);
    wr(4'd1, 4'd1, 5'd21, 8'h3C);
    set_rd(4'd1, 4'd1, 1'b0); tick();
    check_outs("bank0", 5, 8'hA5);
    set_rd(4'd1, 4'd1, 1'b1); tick();
    check_outs("bank1", 5, 8'h3C);

    // Full load then back-to-back readback of all 128 tuples
    for (int ch = 0; ch < 32; ch++)
      for (int y = 1; y <= 8; y++)
        for (int x = 1; x <= 8; x++)
          wr(4'(x), 4'(y), 5'(ch), pattern(ch, x, y));
    for (int b = 0; b < 2; b++)
      for (int y = 1; y <= 8; y++)
        for (int x = 1; x <= 8; x++) begin
          set_rd(4'(x), 4'(y), 1'(b));
          tick();
          for (int k = 0; k < 16; k++)
            check($sformatf("sweep b%0d y%0d x%0d q%0d", b, y, x, k),
                  32'(q[k]), 32'(pattern(b * 16 + k, x, y)));
        end

    // Padding on out-of-range coordinates
    set_rd(4'd0, 4'd4, 1'b0); tick(); check_outs("pad x0", -1, 8'h00);
    set_rd(4'd9, 4'd4, 1'b1); tick(); check_outs("pad x9", -1, 8'h00);
    set_rd(4'd4, 4'd0, 1'b0); tick(); check_outs("pad y0", -1, 8'h00);
    set_rd(4'd4, 4'd9, 1'b1); tick(); check_outs("pad y9", -1, 8'h00);
    wr(4'd9, 4'd4, 5'd3, 8'hFF);
    set_rd(4'd8, 4'd4, 1'b0); tick();
    check("x9 write dropped", 32'(q[3]), 32'hDF);

    // Read-before-write collision on (8,8) ch0
    wr(4'd8, 4'd8, 5'd0, 8'h11);
    set_rd(4'd8, 4'd8, 1'b0);
    write_x = 4'd8; write_y = 4'd8; write_channel = 5'd0; write_data = 8'h22; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    check("collision old", 32'(q[0]), 32'h11);
    tick();
    check("collision new", 32'(q[0]), 32'h22);

    // Reset after loading, then again mid-init at cycle 50
    #2 rst_n = 1'b0;
    #1;
    check("rst run ready", 32'(ready), 32'd0);
    check_outs("rst run", -1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) tick();
    check("pre mid-init ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst init ready", 32'(ready), 32'd0);
    set_rd(4'd1, 4'd1, 1'b0);
    release_and_init("reinit");
    tick();
    check_outs("cleared b0", -1, 8'h00);
    set_rd(4'd8, 4'd8, 1'b1); tick();
    check_outs("cleared b1", -1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
